matrix_frame_scheduler: RTL and testbench

Sequencing controller for the 8x8 APA102-style LED matrix frame serializer. Holds a short message of glyph codes, requests one full frame at a time from the serializer (start frame, 64 LED words, end frame), repeats each glyph for a programmable number of frames, then advances to the next character with wrap-around. It sits between host-side message configuration and the serializer's request/ack/done handshake.

---
 rtl/matrix_pkg.sv | 29 ++
 rtl/matrix_msg_buffer.sv | 44 ++++
 rtl/matrix_frame_scheduler.sv | 126 ++++++++++++
 tb/tb_matrix_frame_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Purpose  : Shared types and constants for the LED matrix frame scheduler.
// Revision : 1.0
// ============================================================================
package matrix_pkg;

    localparam int GLYPH_W    = 5;
    localparam int LED_WORD_W = 32;

    localparam logic [GLYPH_W-1:0]    GLYPH_BLANK      = 5'd26;
    localparam logic [LED_WORD_W-1:0] DEFAULT_FG_COLOR = 32'hF00F0000;
    localparam logic [LED_WORD_W-1:0] DEFAULT_BG_COLOR = 32'hF0000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_EVAL = 2'd3
    } sched_state_t;

    // Codes above the last letter all render as the blank glyph.
    function automatic logic [GLYPH_W-1:0] map_glyph(input logic [GLYPH_W-1:0] code);
        return (code > GLYPH_BLANK) ? GLYPH_BLANK : code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_msg_buffer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_msg_buffer
// Purpose  : MSG_LEN x 5 glyph register file, sync write, async read.
// Revision : 1.0
// ============================================================================
module matrix_msg_buffer
    import matrix_pkg::*;
#(
    parameter int MSG_LEN = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [GLYPH_W-1:0]         wr_char,
    input  logic [$clog2(MSG_LEN)-1:0] rd_addr,
    output logic [GLYPH_W-1:0]         rd_char
);

    logic [MSG_LEN-1:0][GLYPH_W-1:0] mem_q;
    logic [MSG_LEN-1:0][GLYPH_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_char;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                mem_q[i] <= GLYPH_BLANK;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_char = mem_q[rd_addr];

endmodule
`default_nettype wire

// File: rtl/matrix_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : matrix_frame_scheduler
// Purpose  : Requests one LED frame at a time, holding each message glyph
//            for HOLD_FRAMES frames before advancing with wrap-around.
// Revision : 1.0
// ============================================================================
module matrix_frame_scheduler
    import matrix_pkg::*;
#(
    parameter int                     MSG_LEN     = 8,
    parameter int                     HOLD_FRAMES = 16,
    parameter logic [LED_WORD_W-1:0]  FG_COLOR    = DEFAULT_FG_COLOR,
    parameter logic [LED_WORD_W-1:0]  BG_COLOR    = DEFAULT_BG_COLOR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [GLYPH_W-1:0]         wr_char,
    input  logic [$clog2(MSG_LEN):0]   msg_len,
    output logic                       frame_req,
    output logic [GLYPH_W-1:0]         glyph,
    output logic [LED_WORD_W-1:0]      fg_color,
    output logic [LED_WORD_W-1:0]      bg_color,
    input  logic                       frame_ack,
    input  logic                       frame_done,
    output logic [$clog2(MSG_LEN)-1:0] char_idx,
    output logic                       busy
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int LW = AW + 1;
    localparam int HW = $clog2(HOLD_FRAMES) + 1;

    localparam logic [HW-1:0] c_HOLD_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic [LW-1:0] c_MSG_MAX   = LW'(MSG_LEN);

    sched_state_t       state_q,    state_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [AW-1:0]      char_idx_q, char_idx_d;
    logic [GLYPH_W-1:0] glyph_q,    glyph_d;

    logic [GLYPH_W-1:0] w_buf_char;
    logic [LW-1:0]      w_eff_len;
    logic [LW-1:0]      w_idx_inc;

    // Read at the next index so an EVAL->REQ entry sees the advanced character.
    matrix_msg_buffer #(
        .MSG_LEN (MSG_LEN)
    ) u_msg_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_char (wr_char),
        .rd_addr (char_idx_d),
        .rd_char (w_buf_char)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            char_idx_q <= '0;
            glyph_q    <= GLYPH_BLANK;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            char_idx_q <= char_idx_d;
            glyph_q    <= glyph_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_REQ;
            ST_REQ: begin
                if (frame_ack && frame_done) begin
                    state_d = ST_EVAL;
                end else if (frame_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: if (frame_done) state_d = ST_EVAL;
            ST_EVAL: state_d = enable ? ST_REQ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        char_idx_d = char_idx_q;
        w_eff_len  = (msg_len == '0)      ? LW'(1)    :
                     (msg_len > c_MSG_MAX) ? c_MSG_MAX : msg_len;
        w_idx_inc  = {1'b0, char_idx_q} + LW'(1);
        if (state_q == ST_EVAL) begin
            if (hold_cnt_q == c_HOLD_LAST) begin
                hold_cnt_d = '0;
                char_idx_d = (w_idx_inc >= w_eff_len) ? '0 : w_idx_inc[AW-1:0];
            end else begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end
    end

    always_comb begin
        glyph_d = glyph_q;
        if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
            glyph_d = map_glyph(w_buf_char);
        end
    end

    always_comb begin
        frame_req = (state_q == ST_REQ);
        busy      = (state_q != ST_IDLE);
        glyph     = glyph_q;
        char_idx  = char_idx_q;
        fg_color  = FG_COLOR;
        bg_color  = BG_COLOR;
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_frame_scheduler
// Purpose  : Directed, table-driven checks of the frame scheduler.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_matrix_frame_scheduler;
    import matrix_pkg::*;

    localparam int MSG_LEN = 8;
    localparam int HOLD    = 2;
    localparam int AW      = 3;

    logic          clk = 1'b0;
    logic          reset, enable, wr_en, frame_ack, frame_done;
    logic [AW-1:0] wr_addr;
    logic [4:0]    wr_char;
    logic [AW:0]   msg_len;
    logic          frame_req, busy;
    logic [4:0]    glyph;
    logic [31:0]   fg_color, bg_color;
    logic [AW-1:0] char_idx;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]    g;
        logic [AW-1:0] idx;
    } frame_vec_t;

    typedef struct {
        logic [4:0] wr;
        logic [4:0] exp;
    } map_vec_t;

    always #5 clk = ~clk;

    matrix_frame_scheduler #(
        .MSG_LEN     (MSG_LEN),
        .HOLD_FRAMES (HOLD),
        .FG_COLOR    (32'hF00F0000),
        .BG_COLOR    (32'hF0000000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .msg_len    (msg_len),
        .frame_req  (frame_req),
        .glyph      (glyph),
        .fg_color   (fg_color),
        .bg_color   (bg_color),
        .frame_ack  (frame_ack),
        .frame_done (frame_done),
        .char_idx   (char_idx),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; wr_en = 1'b0;
        frame_ack = 1'b0; frame_done = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_buf(input logic [AW-1:0] a, input logic [4:0] c);
        wr_en = 1'b1; wr_addr = a; wr_char = c;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!frame_req && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(frame_req), 32'd1);
    endtask

    // Serializer model: ack at once, done 5 cycles later; leaves DUT in EVAL.
    task automatic run_frame(input string name, input bit keep_en,
                             output logic [4:0] g, output logic [AW-1:0] idx);
        wait_req(name);
        g = glyph;
        idx = char_idx;
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        enable = keep_en;
        repeat (4) tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_vec_t    seq [8];
        map_vec_t      maps [6];
        logic [4:0]    g;
        logic [AW-1:0] idx;

        seq[0] = '{5'd0, 3'd0}; seq[1] = '{5'd0, 3'd0};
        seq[2] = '{5'd1, 3'd1}; seq[3] = '{5'd1, 3'd1};
        seq[4] = '{5'd2, 3'd2}; seq[5] = '{5'd2, 3'd2};
        seq[6] = '{5'd0, 3'd0}; seq[7] = '{5'd0, 3'd0};

        maps[0] = '{5'd0,  5'd0};  maps[1] = '{5'd25, 5'd25};
        maps[2] = '{5'd26, 5'd26}; maps[3] = '{5'd31, 5'd26};
        maps[4] = '{5'd13, 5'd13}; maps[5] = '{5'd27, 5'd26};

        wr_addr = '0; wr_char = '0; msg_len = '0;
        do_reset();

        check("rst_frame_req", 32'(frame_req), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_glyph",     32'(glyph),     32'd26);
        check("rst_char_idx",  32'(char_idx),  32'd0);
        check("rst_fg",        fg_color,       32'hF00F0000);
        check("rst_bg",        bg_color,       32'hF0000000);

        // Main sequence: three characters, each held for two frames.
        write_buf(3'd0, 5'd0);
        write_buf(3'd1, 5'd1);
        write_buf(3'd2, 5'd2);
        msg_len = 4'd3;
        enable  = 1'b1;
        tick();
        check("en_to_req", 32'(frame_req), 32'd1);
        for (int i = 0; i < 8; i++) begin
            run_frame("main_req", 1'b1, g, idx);
            check($sformatf("main_glyph_%0d", i), 32'(g),   32'(seq[i].g));
            check($sformatf("main_idx_%0d", i),   32'(idx), 32'(seq[i].idx));
            if (i == 0) begin
                check("turn_eval", {30'd0, busy, frame_req}, 32'd2);
                tick();
                check("turn_req", 32'(frame_req), 32'd1);
            end
        end

        // Glyph code mapping.
        do_reset();
        msg_len = 4'd1;
        for (int i = 0; i < 6; i++) begin
            write_buf(3'd0, maps[i].wr);
            enable = 1'b1;
            run_frame("map_req", 1'b0, g, idx);
            check($sformatf("map_glyph_%0d", maps[i].wr), 32'(g), 32'(maps[i].exp));
            tick();
        end

        // Write to the active character during WAIT.
        do_reset();
        msg_len = 4'd1;
        write_buf(3'd0, 5'd5);
        enable = 1'b1;
        wait_req("wwait_req");
        check("wwait_glyph0", 32'(glyph), 32'd5);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        write_buf(3'd0, 5'd9);
        check("wwait_inflight", 32'(glyph), 32'd5);
        tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        wait_req("wwait_req2");
        check("wwait_next", 32'(glyph), 32'd9);

        // Ack and done in the same cycle.
        do_reset();
        write_buf(3'd0, 5'd3);
        write_buf(3'd1, 5'd4);
        msg_len = 4'd2;
        enable = 1'b1;
        wait_req("same_req0");
        check("same_glyph0", 32'(glyph), 32'd3);
        frame_ack = 1'b1; frame_done = 1'b1;
        tick();
        frame_ack = 1'b0; frame_done = 1'b0;
        check("same_eval", {30'd0, busy, frame_req}, 32'd2);
        tick();
        check("same_req", 32'(frame_req), 32'd1);
        run_frame("same_f1", 1'b1, g, idx);
        check("same_glyph1", 32'(g), 32'd3);
        run_frame("same_f2", 1'b1, g, idx);
        check("same_glyph2", 32'(g), 32'd4);
        check("same_idx2", 32'(idx), 32'd1);

        // msg_len of zero behaves as one.
        do_reset();
        write_buf(3'd0, 5'd7);
        write_buf(3'd1, 5'd8);
        msg_len = 4'd0;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_frame("len0_req", 1'b1, g, idx);
            check($sformatf("len0_idx_%0d", i),   32'(idx), 32'd0);
            check($sformatf("len0_glyph_%0d", i), 32'(g),   32'd7);
        end

        // Shrinking msg_len below char_idx wraps at the next advance.
        do_reset();
        msg_len = 4'd6;
        enable = 1'b1;
        for (int f = 0; f < 13; f++) begin
            if (f == 11) msg_len = 4'd2;
            run_frame("shr_req", 1'b1, g, idx);
            if (f == 10) begin
                check("shr_idx5", 32'(idx), 32'd5);
                check("shr_blank", 32'(g), 32'd26);
            end
            if (f == 12) check("shr_wrap", 32'(idx), 32'd0);
        end

        // Reset while waiting for frame_done.
        do_reset();
        write_buf(3'd1, 5'd2);
        msg_len = 4'd3;
        enable = 1'b1;
        run_frame("rw_f0", 1'b1, g, idx);
        run_frame("rw_f1", 1'b1, g, idx);
        wait_req("rw_req2");
        check("rw_pre_idx", 32'(char_idx), 32'd1);
        check("rw_pre_glyph", 32'(glyph), 32'd2);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        reset = 1'b1; enable = 1'b0;
        tick();
        reset = 1'b0;
        check("rw_frame_req", 32'(frame_req), 32'd0);
        check("rw_busy",      32'(busy),      32'd0);
        check("rw_idx",       32'(char_idx),  32'd0);
        check("rw_glyph",     32'(glyph),     32'd26);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check("rw_done_busy", 32'(busy), 32'd0);
        tick();
        check("rw_done_req", 32'(frame_req), 32'd0);

        // Drop enable during WAIT: one EVAL then IDLE.
        do_reset();
        msg_len = 4'd1;
        enable = 1'b1;
        run_frame("dis_req", 1'b0, g, idx);
        check("dis_eval", {30'd0, busy, frame_req}, 32'd2);
        tick();
        check("dis_idle_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("dis_idle_req", 32'(frame_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
